seq_alu: RTL and testbench

Sequential 16-bit execution unit for the lab CPU datapath. Sits directly upstream of the status detector: drives the Z bus result, the carry out of bit 15 and the carry into bit 15, from which the detector derives Z, V, S and C. Logic and add/subtract complete in one cycle. Shifts and multiply iterate under a small state machine with a start/busy/done handshake.

---
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 tb/tb_seq_alu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done handshake plus operand and result buses
// for the sequential 16-bit execution unit. The master drives the request
// and the slave (seq_alu) returns the status and result.
interface seq_alu_if;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] zbus;
    logic        ci;
    logic        ci_1;

    modport master (
        output start, op, a, b,
        input  busy, done, zbus, ci, ci_1
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, zbus, ci, ci_1
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential 16-bit execution unit feeding the status detector.
// Logic and add/subtract finish in one cycle. Shifts move one bit per clock
// and multiply runs 16 shift-add steps. The result, the carry out of bit 15
// (ci) and the carry into bit 15 (ci_1) are held until the next done pulse.
// Optional feature macro: SEQ_ALU_MUL_EN enables op 9 (MUL) and its datapath.
// Without it, op 9 behaves as a reserved single-cycle op.
module seq_alu (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave alu
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] MUL   = 2'd2;
    localparam logic [3:0] OP_MUL  = 4'd9;
`endif

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd10;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [15:0] r_sh;
    logic [3:0]  r_shop;
    logic        r_done;
    logic [15:0] r_zbus;
    logic        r_ci;
    logic        r_ci_1;

    logic [15:0] w_b_eff;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [15:0] w_res;
    logic        w_res_ci;
    logic        w_res_ci_1;
    logic        w_is_shift;
    logic        w_shift_go;
    logic [15:0] w_sh_next;
    logic        w_sh_out;

`ifdef SEQ_ALU_MUL_EN
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [15:0] r_mplr;
    logic [31:0] w_acc_next;
    logic        w_mul_hi;
`endif

    assign alu.busy = (r_state != IDLE);
    assign alu.done = r_done;
    assign alu.zbus = r_zbus;
    assign alu.ci   = r_ci;
    assign alu.ci_1 = r_ci_1;

    // Single-cycle result and flags for the op presented with start.
    // Carry into bit 15 is recovered as sum[15] ^ a[15] ^ b_eff[15].
    always_comb begin
        w_b_eff    = (alu.op == OP_SUB) ? ~alu.b : alu.b;
        w_cin      = (alu.op == OP_SUB);
        w_sum      = {1'b0, alu.a} + {1'b0, w_b_eff} + {16'd0, w_cin};
        w_is_shift = (alu.op == OP_SHL) || (alu.op == OP_SHR) || (alu.op == OP_ASR);
        w_shift_go = w_is_shift && (alu.b[3:0] != 4'd0);
        w_res      = '0;
        w_res_ci   = 1'b0;
        w_res_ci_1 = 1'b0;
        case (alu.op)
            OP_ADD, OP_SUB: begin
                w_res      = w_sum[15:0];
                w_res_ci   = w_sum[16];
                w_res_ci_1 = w_sum[15] ^ alu.a[15] ^ w_b_eff[15];
            end
            OP_AND:  w_res = alu.a & alu.b;
            OP_OR:   w_res = alu.a | alu.b;
            OP_XOR:  w_res = alu.a ^ alu.b;
            OP_NOT:  w_res = ~alu.a;
            OP_PASS: w_res = alu.b;
            OP_SHL, OP_SHR, OP_ASR: w_res = alu.a;
            default: w_res = '0;
        endcase
    end

    // One-bit shift step of the held operand and the bit it pushes out.
    always_comb begin
        w_sh_next = {r_sh[15], r_sh[15:1]};
        w_sh_out  = r_sh[0];
        case (r_shop)
            OP_SHL: begin
                w_sh_next = {r_sh[14:0], 1'b0};
                w_sh_out  = r_sh[15];
            end
            OP_SHR: begin
                w_sh_next = {1'b0, r_sh[15:1]};
                w_sh_out  = r_sh[0];
            end
            default: begin
                w_sh_next = {r_sh[15], r_sh[15:1]};
                w_sh_out  = r_sh[0];
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // One shift-add multiply step: accumulate the shifted multiplicand.
    always_comb begin
        w_acc_next = r_acc + (r_mplr[0] ? r_mcand : 32'd0);
        w_mul_hi   = |w_acc_next[31:16];
    end
`endif

    // Control FSM and result registers; outputs change only with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_sh    <= '0;
            r_shop  <= '0;
            r_done  <= 1'b0;
            r_zbus  <= '0;
            r_ci    <= 1'b0;
            r_ci_1  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (alu.start) begin
                        if (w_shift_go) begin
                            r_sh    <= alu.a;
                            r_shop  <= alu.op;
                            r_count <= {1'b0, alu.b[3:0]};
                            r_state <= SHIFT;
                        end
`ifdef SEQ_ALU_MUL_EN
                        else if (alu.op == OP_MUL) begin
                            r_acc   <= '0;
                            r_mcand <= {16'd0, alu.a};
                            r_mplr  <= alu.b;
                            r_count <= 5'd16;
                            r_state <= MUL;
                        end
`endif
                        else begin
                            r_zbus <= w_res;
                            r_ci   <= w_res_ci;
                            r_ci_1 <= w_res_ci_1;
                            r_done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_sh    <= w_sh_next;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_zbus  <= w_sh_next;
                        r_ci    <= w_sh_out;
                        r_ci_1  <= w_sh_out;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= {r_mcand[30:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[15:1]};
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_zbus  <= w_acc_next[15:0];
                        r_ci    <= w_mul_hi;
                        r_ci_1  <= w_mul_hi;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu results, flags and handshake
// timing, including ignored starts while busy and reset mid-operation.
module tb_seq_alu;
    logic clk;
    logic reset;
    int unsigned n_checks;
    int unsigned n_errors;

    seq_alu_if alu ();

    seq_alu dut (
        .clk   (clk),
        .reset (reset),
        .alu   (alu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu.start = 1'b1;
        alu.op    = op;
        alu.a     = a;
        alu.b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] z, input logic c, input logic c1);
        chk({tag, ".done"}, {31'd0, alu.done}, 32'd1);
        chk({tag, ".busy"}, {31'd0, alu.busy}, 32'd0);
        chk({tag, ".zbus"}, {16'd0, alu.zbus}, {16'd0, z});
        chk({tag, ".ci"},   {31'd0, alu.ci},   {31'd0, c});
        chk({tag, ".ci_1"}, {31'd0, alu.ci_1}, {31'd0, c1});
    endtask

    task automatic chk_busy(input string tag, input logic [15:0] held);
        chk({tag, ".busy"}, {31'd0, alu.busy}, 32'd1);
        chk({tag, ".done"}, {31'd0, alu.done}, 32'd0);
        chk({tag, ".held"}, {16'd0, alu.zbus}, {16'd0, held});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        alu.start = 1'b0;
        alu.op    = 4'd0;
        alu.a     = 16'd0;
        alu.b     = 16'd0;
        step();
        step();
        chk("rst.busy", {31'd0, alu.busy}, 32'd0);
        chk("rst.done", {31'd0, alu.done}, 32'd0);
        chk("rst.zbus", {16'd0, alu.zbus}, 32'd0);
        chk("rst.ci",   {31'd0, alu.ci},   32'd0);
        chk("rst.ci_1", {31'd0, alu.ci_1}, 32'd0);
        reset = 1'b0;
        step();

        // back-to-back single-cycle ops
        issue(4'd0, 16'h7FFF, 16'h0001);
        chk_res("add", 16'h8000, 1'b0, 1'b1);
        issue(4'd1, 16'h0005, 16'h0005);
        chk_res("sub", 16'h0000, 1'b1, 1'b1);
        issue(4'd2, 16'hF0F0, 16'h0FF0);
        chk_res("and", 16'h00F0, 1'b0, 1'b0);
        alu.start = 1'b0;
        step();
        chk("idle.done", {31'd0, alu.done}, 32'd0);
        chk("idle.zbus", {16'd0, alu.zbus}, 32'h00F0);

        issue(4'd3, 16'h1200, 16'h0034);
        chk_res("or", 16'h1234, 1'b0, 1'b0);
        issue(4'd4, 16'hFFFF, 16'h0F0F);
        chk_res("xor", 16'hF0F0, 1'b0, 1'b0);
        issue(4'd5, 16'h00FF, 16'h1234);
        chk_res("not", 16'hFF00, 1'b0, 1'b0);
        issue(4'd10, 16'h1111, 16'hBEEF);
        chk_res("pass", 16'hBEEF, 1'b0, 1'b0);
        issue(4'd12, 16'hFFFF, 16'hFFFF);
        chk_res("rsvd", 16'h0000, 1'b0, 1'b0);
        issue(4'd0, 16'h8000, 16'h8000);
        chk_res("add_ovf", 16'h0000, 1'b1, 1'b0);
        issue(4'd1, 16'h0000, 16'h0001);
        chk_res("sub_borrow", 16'hFFFF, 1'b0, 1'b0);

        // SHL by 1: result after edge k+1
        issue(4'd6, 16'h8001, 16'h0001);
        alu.start = 1'b0;
        chk_busy("shl.k", 16'hFFFF);
        step();
        chk_res("shl", 16'h0002, 1'b1, 1'b1);
        step();
        chk("shl.pulse", {31'd0, alu.done}, 32'd0);

        // ASR by 4: busy for 4 cycles
        issue(4'd8, 16'h8000, 16'h0004);
        alu.start = 1'b0;
        chk_busy("asr.k", 16'h0002);
        step();
        step();
        step();
        chk_busy("asr.k3", 16'h0002);
        step();
        chk_res("asr", 16'hF800, 1'b0, 1'b0);

        // shift by zero completes in one cycle
        issue(4'd8, 16'h9234, 16'h0010);
        chk_res("asr0", 16'h9234, 1'b0, 1'b0);

        // SHR by 15 with an ignored ADD start during the shift
        issue(4'd7, 16'hC000, 16'h000F);
        alu.start = 1'b0;
        step();
        step();
        issue(4'd0, 16'h0001, 16'h0001);
        alu.start = 1'b0;
        chk_busy("shr.k3", 16'h9234);
        repeat (11) step();
        chk_busy("shr.k14", 16'h9234);
        step();
        chk_res("shr15", 16'h0001, 1'b1, 1'b1);
        step();
        chk("shr.noadd.done", {31'd0, alu.done}, 32'd0);
        chk("shr.noadd.zbus", {16'd0, alu.zbus}, 32'h0001);

        // reset in the middle of a shift
        issue(4'd8, 16'h8000, 16'h0008);
        alu.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("srst.busy", {31'd0, alu.busy}, 32'd0);
        chk("srst.done", {31'd0, alu.done}, 32'd0);
        chk("srst.zbus", {16'd0, alu.zbus}, 32'd0);
        chk("srst.ci",   {31'd0, alu.ci},   32'd0);
        step();
        reset = 1'b0;
        step();
        chk("srst.nodone", {31'd0, alu.done}, 32'd0);
        issue(4'd0, 16'h0001, 16'h0001);
        alu.start = 1'b0;
        chk_res("srst.add", 16'h0002, 1'b0, 1'b0);

`ifdef SEQ_ALU_MUL_EN
        issue(4'd9, 16'h0100, 16'h0100);
        alu.start = 1'b0;
        chk_busy("mul.k", 16'h0002);
        repeat (15) step();
        chk_busy("mul.k15", 16'h0002);
        step();
        chk_res("mul_hi", 16'h0000, 1'b1, 1'b1);

        issue(4'd9, 16'h0003, 16'h0007);
        alu.start = 1'b0;
        repeat (16) step();
        chk_res("mul_3x7", 16'h0015, 1'b0, 1'b0);

        // ADD presented at step 3 of a MUL is ignored
        issue(4'd9, 16'h1234, 16'h0010);
        alu.start = 1'b0;
        step();
        step();
        issue(4'd0, 16'h0001, 16'h0001);
        alu.start = 1'b0;
        chk_busy("mul.ign", 16'h0015);
        repeat (12) step();
        chk_busy("mul.ign15", 16'h0015);
        step();
        chk_res("mul_ign", 16'h2340, 1'b1, 1'b1);
        step();
        chk("mul.noadd.done", {31'd0, alu.done}, 32'd0);
        chk("mul.noadd.zbus", {16'd0, alu.zbus}, 32'h2340);

        // reset at step 5 of a MUL
        issue(4'd9, 16'h0003, 16'h0007);
        alu.start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mrst.busy", {31'd0, alu.busy}, 32'd0);
        chk("mrst.done", {31'd0, alu.done}, 32'd0);
        chk("mrst.zbus", {16'd0, alu.zbus}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("mrst.nodone", {31'd0, alu.done}, 32'd0);
        issue(4'd0, 16'h0001, 16'h0001);
        alu.start = 1'b0;
        chk_res("mrst.add", 16'h0002, 1'b0, 1'b0);
`else
        issue(4'd9, 16'h0003, 16'h0007);
        alu.start = 1'b0;
        chk_res("op9_rsvd", 16'h0000, 1'b0, 1'b0);
        step();
        chk("op9.pulse", {31'd0, alu.done}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
